// File: rtl/multi_pattern_neuron.sv
// Serial spiking neuron holding NUM_PATTERNS (target, response) pairs loaded over CONTROL.
// Build option HAMMING_MATCH_EN: match within TOL differing bits instead of exact equality.
module multi_pattern_neuron #(
    parameter  int MEMORY       = 8,
    parameter  int NUM_PATTERNS = 4,
    parameter  int REFRACT_W    = 4,
    localparam int IW           = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CONTROL,
    input  logic          SEQ_IN,
    output logic          SEQ_OUT,
    output logic          FIRING,
    output logic [IW-1:0] MATCH_IDX,
    output logic          CFG_DONE,
    output logic [1:0]    DBG_STATE
);

    localparam int TW       = $clog2(MEMORY + 1);
    localparam int CFG_BITS = NUM_PATTERNS * 2 * MEMORY + REFRACT_W + TW;
    localparam int CCW      = $clog2(CFG_BITS + 1);
    localparam int CW       = ($clog2(MEMORY) > REFRACT_W) ? $clog2(MEMORY) : REFRACT_W;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_LISTEN  = 2'd1,
        S_FIRE    = 2'd2,
        S_REFRACT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CFG_BITS-1:0]   r_cfg;
    logic [CCW-1:0]        r_cfg_cnt;
    logic [MEMORY-1:0]     r_in_buf;
    logic [MEMORY-1:0]     r_out_buf;
    logic [CW-1:0]         r_cnt;
    logic                  r_seq_out;
    logic [IW-1:0]         r_match_idx;

    logic [REFRACT_W-1:0]  w_refract;
    logic [CW-1:0]         w_refract_last;
    logic [MEMORY-1:0]     w_tgt;
    logic                  w_cand;
    logic                  w_hit;
    logic [IW-1:0]         w_idx;
    logic [MEMORY-1:0]     w_resp;

    // Shifted MSB-first, so T0 lands in the top bits and TOL in the bottom TW bits.
    assign w_refract      = r_cfg[TW +: REFRACT_W];
    assign w_refract_last = CW'(w_refract) - CW'(1);

`ifdef HAMMING_MATCH_EN
    logic [TW-1:0] w_tol;
    logic [TW-1:0] w_dist;
    assign w_tol = r_cfg[TW-1:0];
`else
    logic w_unused_tol;
    assign w_unused_tol = ^r_cfg[TW-1:0];
`endif

    // Walk from the highest index down so the lowest matching entry is the one left standing.
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_resp = '0;
        w_tgt  = '0;
        w_cand = 1'b0;
`ifdef HAMMING_MATCH_EN
        w_dist = '0;
`endif
        for (int p = NUM_PATTERNS - 1; p >= 0; p--) begin
            w_tgt = r_cfg[CFG_BITS - 1 - 2 * p * MEMORY -: MEMORY];
`ifdef HAMMING_MATCH_EN
            w_dist = '0;
            for (int b = 0; b < MEMORY; b++) begin
                w_dist = w_dist + TW'(r_in_buf[b] ^ w_tgt[b]);
            end
            w_cand = (w_tgt != '0) && (w_dist <= w_tol);
`else
            w_cand = (w_tgt != '0) && (r_in_buf == w_tgt);
`endif
            if (w_cand) begin
                w_hit  = 1'b1;
                w_idx  = IW'(p);
                w_resp = r_cfg[CFG_BITS - 1 - (2 * p + 1) * MEMORY -: MEMORY];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD: begin
                if (r_cfg_cnt == CCW'(CFG_BITS - 1)) begin
                    w_next_state = S_LISTEN;
                end
            end
            S_LISTEN: begin
                if (w_hit) begin
                    w_next_state = S_FIRE;
                end
            end
            S_FIRE: begin
                if (r_cnt == CW'(MEMORY - 1)) begin
                    w_next_state = (w_refract != '0) ? S_REFRACT : S_LISTEN;
                end
            end
            S_REFRACT: begin
                if (r_cnt == w_refract_last) begin
                    w_next_state = S_LISTEN;
                end
            end
            default: w_next_state = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cfg       <= '0;
            r_cfg_cnt   <= '0;
            r_in_buf    <= '0;
            r_out_buf   <= '0;
            r_cnt       <= '0;
            r_seq_out   <= 1'b0;
            r_match_idx <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_cfg     <= {r_cfg[CFG_BITS-2:0], CONTROL};
                    r_cfg_cnt <= r_cfg_cnt + CCW'(1);
                    r_in_buf  <= '0;
                    r_seq_out <= 1'b0;
                end
                S_LISTEN: begin
                    r_seq_out <= 1'b0;
                    if (w_hit) begin
                        r_out_buf   <= w_resp;
                        r_match_idx <= w_idx;
                        r_in_buf    <= '0;
                        r_cnt       <= '0;
                    end else begin
                        r_in_buf <= {r_in_buf[MEMORY-2:0], SEQ_IN};
                    end
                end
                S_FIRE: begin
                    r_seq_out <= r_out_buf[MEMORY-1];
                    r_out_buf <= {r_out_buf[MEMORY-2:0], 1'b0};
                    // Reuse the counter for the refractory phase, so restart it on the way out.
                    if (r_cnt == CW'(MEMORY - 1)) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_REFRACT: begin
                    r_seq_out <= 1'b0;
                    r_in_buf  <= '0;
                    r_cnt     <= r_cnt + CW'(1);
                end
                default: begin
                    r_seq_out <= 1'b0;
                end
            endcase
        end
    end

    assign SEQ_OUT   = r_seq_out;
    assign FIRING    = (r_state == S_FIRE);
    assign MATCH_IDX = r_match_idx;
    assign CFG_DONE  = (r_state != S_LOAD);
    assign DBG_STATE = r_state;

endmodule
